// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst scheduler sharing one async-FIFO read port among N_REQ consumers
module fifo_rd_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                   rclk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] burst_len,
  input  logic                   rdy,
  input  logic                   rempty,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic                   rinc,
  output logic [N_REQ-1:0]       gnt,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy
);
  localparam int PTR_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [PTR_W-1:0] rr_ptr, sel;
  logic [LEN_W-1:0] remaining, len_raw, len_eff;
  int idx;
  // scan from the farthest candidate inward so the nearest requester after rr_ptr wins
  always_comb begin
    sel = rr_ptr;
    idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req[idx]) sel = PTR_W'(idx);
    end
  end
  assign len_raw   = burst_len[int'(sel)*LEN_W +: LEN_W];
  assign len_eff   = len_raw == '0 ? LEN_W'(1) : len_raw > LEN_W'(MAX_BURST) ? LEN_W'(MAX_BURST) : len_raw;
  assign busy      = state == BURST;
  assign out_valid = busy & ~rempty;
  assign rinc      = out_valid & rdy;
  assign out_last  = out_valid & (remaining == LEN_W'(1));
  assign out_data  = rdata;
  always_ff @(negedge rclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= PTR_W'(N_REQ - 1);
      remaining <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state     <= BURST;
        gnt       <= N_REQ'(1) << sel;
        rr_ptr    <= sel;
        remaining <= len_eff;
      end
    end else if (rinc) begin
      remaining <= remaining - LEN_W'(1);
      if (remaining == LEN_W'(1)) begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: randomized scoreboard bench with a queue-based FIFO and burst-plan reference model
module tb_fifo_rd_arbiter;
  localparam int N = 4, DW = 16, MB = 16, LW = 5;
  logic rclk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*LW-1:0] burst_len = '0;
  logic rdy = 0, rempty = 1;
  logic [DW-1:0] rdata = '0;
  logic rinc, out_valid, out_last, busy;
  logic [N-1:0] gnt;
  logic [DW-1:0] out_data;
  int checks = 0, failures = 0, grants = 0, xfers = 0, mptr = N - 1;
  logic [DW-1:0] fifo[$], wq[$];
  int exp_own[$];
  bit exp_last[$];
  bit prev_busy = 0, prev_end = 0, pop_now = 0;
  int m_own;
  bit m_last;
  logic [DW-1:0] m_data;

  fifo_rd_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .LEN_W(LW)) dut (
    .rclk(rclk), .reset(reset), .req(req), .burst_len(burst_len), .rdy(rdy),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .gnt(gnt), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic upd();
    rempty = fifo.size() == 0;
    rdata  = rempty ? '0 : fifo[0];
  endtask

  task automatic push_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    fifo.push_back(w);
    wq.push_back(w);
    upd();
  endtask

  // the FIFO read pointer advances on the falling edge where rinc was high
  always @(negedge rclk) begin
    pop_now = rinc;
    #1;
    if (pop_now && fifo.size() > 0) begin
      void'(fifo.pop_front());
      upd();
    end
  end

  always @(posedge rclk) begin
    if (!reset) begin
      chk("no_underflow", rinc & rempty, 0);
      chk("gnt_shape", busy ? $onehot(gnt) : (gnt == '0), 1);
      chk("valid", out_valid, busy & ~rempty);
      if (prev_end) chk("idle_gap", busy, 0);
      if (busy && !prev_busy) grants++;
      prev_busy = busy;
      prev_end = 0;
      if (out_valid && rdy) begin
        xfers++;
        if (exp_own.size() == 0 || wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer got gnt=%0h want no transfer at %0t", gnt, $time);
        end else begin
          m_own = exp_own.pop_front();
          m_last = exp_last.pop_front();
          m_data = wq.pop_front();
          chk("grant_owner", gnt, 32'(1) << m_own);
          chk("data", out_data, m_data);
          chk("last", out_last, m_last);
          chk("rinc_xfer", rinc, 1);
          prev_end = m_last;
        end
      end else chk("rinc_hold", rinc, 0);
    end else begin
      prev_busy = 0;
      prev_end = 0;
    end
  end

  function automatic logic [LW-1:0] pick_len();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd31;
      2: return 5'd16;
      3: return 5'd17;
      default: return LW'($urandom_range(1, 8));
    endcase
  endfunction

  // reference: whole bursts granted in round-robin order, each clamped to 1..MB words
  task automatic plan(input logic [N-1:0] rq, input logic [N*LW-1:0] lens, input int nb, output int total);
    int sel, eff, ln;
    total = 0;
    for (int b = 0; b < nb; b++) begin
      sel = mptr;
      for (int k = 1; k <= N; k++) begin
        if (rq[(mptr + k) % N]) begin
          sel = (mptr + k) % N;
          break;
        end
      end
      ln = int'(lens[sel*LW +: LW]);
      eff = ln == 0 ? 1 : (ln > MB ? MB : ln);
      for (int j = 0; j < eff; j++) begin
        exp_own.push_back(sel);
        exp_last.push_back(j == eff - 1);
      end
      total += eff;
      mptr = sel;
    end
  endtask

  task automatic episode(input logic [N-1:0] rq, input logic [N*LW-1:0] lens, input int nb);
    int total, g0, budget, pushed;
    @(negedge rclk);
    #2;
    plan(rq, lens, nb, total);
    req = rq;
    burst_len = lens;
    g0 = grants;
    pushed = 0;
    budget = total * 12 + nb * 6 + 40;
    while (budget > 0) begin
      if (exp_own.size() == 0 && !busy && pushed == total) break;
      if (grants - g0 >= nb) req = '0;
      if (pushed < total && $urandom_range(0, 2) != 0) begin
        push_word();
        pushed++;
      end
      rdy = $urandom_range(0, 3) != 0;
      @(negedge rclk);
      #2;
      budget--;
    end
    req = '0;
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL episode_timeout got pending=%0d want pending=0", exp_own.size());
      exp_own.delete();
      exp_last.delete();
      wq.delete();
    end
    repeat (2) @(negedge rclk);
    @(posedge rclk);
    chk("end_idle", {busy, gnt}, 0);
    chk("fifo_drained", fifo.size(), 0);
    fifo.delete();
    upd();
  endtask

  initial begin
    int total, x0, budget;
    logic [N*LW-1:0] lens;
    fifo.push_back(16'h1234);
    upd();
    rdy = 1;
    req = '1;
    burst_len = {4{5'd3}};
    repeat (3) @(posedge rclk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    fifo.delete();
    upd();
    req = '0;
    @(negedge rclk);
    #3 reset = 0;
    episode(4'b0001, {5'd0, 5'd0, 5'd0, 5'd4}, 1);
    episode(4'b1011, {4{5'd2}}, 6);
    episode(4'b0001, 20'd0, 1);
    episode(4'b0001, 20'd31, 1);
    episode(4'b0100, {5'd0, 5'd2, 5'd0, 5'd0}, 2);
    // asynchronous reset two words into a five-word burst
    @(negedge rclk);
    #2;
    plan(4'b0001, 20'd5, 1, total);
    req = 4'b0001;
    burst_len = 20'd5;
    for (int i = 0; i < 5; i++) push_word();
    rdy = 1;
    x0 = xfers;
    budget = 40;
    while (xfers - x0 < 2 && budget > 0) begin
      @(negedge rclk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL rst_wait got xfers=%0d want xfers=2", xfers - x0);
    end
    #3 reset = 1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_rinc", rinc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    exp_own.delete();
    exp_last.delete();
    wq.delete();
    fifo.delete();
    upd();
    mptr = N - 1;
    req = '0;
    @(negedge rclk);
    #3 reset = 0;
    episode(4'b1111, {4{5'd3}}, 4);
    for (int e = 0; e < 30; e++) begin
      for (int r = 0; r < N; r++) lens[r*LW +: LW] = pick_len();
      episode(N'($urandom_range(1, 15)), lens, $urandom_range(1, 6));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
